// File: rtl/coin_pulse_shaper.sv
`default_nettype none
// ============================================================================
// coin_pulse_shaper : sync + debounce + one-shot with lockout and 1-deep queue
// Revision: 1.0
// ============================================================================
module coin_pulse_shaper #(
  parameter int NUM_CH      = 4,
  parameter int TICK_DIV    = 24192,
  parameter int DEB_TICKS   = 8,
  parameter int PULSE_TICKS = 40,
  parameter int GAP_TICKS   = 60
) (
  input  logic              clk_sys,
  input  logic              res_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              enable_i,
  output logic [NUM_CH-1:0] pulse_n_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic              tick_o
);

  localparam int c_TB_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_DEB_W  = $clog2(DEB_TICKS + 1);
  localparam int c_MAX_LD = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int c_CNT_W  = $clog2(c_MAX_LD + 1);

  localparam logic [c_TB_W-1:0]  c_TB_LAST  = c_TB_W'(TICK_DIV - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE_TICKS);
  localparam logic [c_CNT_W-1:0] c_GAP_LD   = c_CNT_W'(GAP_TICKS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PULSE    = 2'd1,
    S_GAP      = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  logic [c_TB_W-1:0] r_tb_cnt;
  logic              r_tick;
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  // Registered strobe: first tick is visible TICK_DIV cycles after reset release.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      r_tb_cnt <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_tick   <= (r_tb_cnt == c_TB_LAST);
      r_tb_cnt <= (r_tb_cnt == c_TB_LAST) ? '0 : r_tb_cnt + c_TB_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= req_i;
      r_sync2 <= r_sync1;
    end
  end

  assign tick_o = r_tick;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic               r_level;
    logic               r_level_d;
    logic               r_pending;
    logic               r_pulse_n;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    state_t             r_state;
    logic               w_rise;

    assign w_rise = r_level & ~r_level_d;

    always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) begin
        r_deb_cnt <= '0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
      end else begin
        r_level_d <= r_level;
        if (r_tick) begin
          if (r_sync2[ch] != r_level) begin
            if (r_deb_cnt == c_DEB_LAST) begin
              r_level   <= ~r_level;
              r_deb_cnt <= '0;
            end else begin
              r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
            end
          end else begin
            r_deb_cnt <= '0;
          end
        end
      end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_pending <= 1'b0;
        r_pulse_n <= 1'b1;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable_i && (w_rise || r_pending)) begin
              r_state   <= S_PULSE;
              r_cnt     <= c_PULSE_LD;
              r_pending <= 1'b0;
              r_pulse_n <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
          S_PULSE: begin
            if (w_rise) r_pending <= 1'b1;
            if (r_cnt == '0) begin
              r_state   <= S_GAP;
              r_cnt     <= c_GAP_LD;
              r_pulse_n <= 1'b1;
            end else if (r_tick) begin
              r_cnt <= r_cnt - c_CNT_W'(1);
            end
          end
          S_GAP: begin
            if (w_rise) r_pending <= 1'b1;
            if (r_cnt == '0) begin
              // A queued press already implies a release, so skip WAIT_REL.
              if (r_pending || w_rise || !r_level) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_WAIT_REL;
              end
            end else if (r_tick) begin
              r_cnt <= r_cnt - c_CNT_W'(1);
            end
          end
          S_WAIT_REL: begin
            if (!r_level) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_pulse_n <= 1'b1;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end

    assign pulse_n_o[ch] = r_pulse_n;
    assign busy_o[ch]    = r_busy;
  end

endmodule
`default_nettype wire
